// File: rtl/bus_fabric_n_pkg.sv
// ============================================================================
// Module   : bus_fabric_n_pkg
// Brief    : Shared state encodings and defaults for the bus fabric.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bus_fabric_n_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_ST_IDLE   = 2'd0;
  localparam state_t c_ST_ACCESS = 2'd1;
  localparam state_t c_ST_DONE   = 2'd2;
  localparam state_t c_ST_ERR    = 2'd3;

  localparam logic [31:0] c_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_addr_match.sv
// ============================================================================
// Module   : bus_addr_match
// Brief    : Combinational base/mask priority decoder; lowest index wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_addr_match
  import bus_fabric_n_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int AW = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_0000}},
  parameter int IW = clog2_min1(NUM_SLAVES)
) (
  input  logic [AW-1:0]         addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [IW-1:0]         idx
);

  logic [NUM_SLAVES-1:0] w_hit;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_hit
    assign w_hit[i] = ((addr ^ SLV_BASE[i*AW +: AW]) & SLV_MASK[i*AW +: AW]) == '0;
  end

  // Scan from the top so the lowest matching index is the last to assign.
  always_comb begin
    hit = |w_hit;
    sel = '0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_fabric_n.sv
// ============================================================================
// Module   : bus_fabric_n
// Brief    : Registered CPU-to-N-slave bus fabric with decode, timeout, bus error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_fabric_n
  import bus_fabric_n_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_0000}},
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = c_ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  input  logic                     cpu_rd,
  input  logic [DW/8-1:0]          cpu_we,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic [NUM_SLAVES-1:0]    slv_sel,
  output logic [AW-1:0]            slv_addr,
  output logic [DW-1:0]            slv_wdata,
  output logic                     slv_rd,
  output logic [DW/8-1:0]          slv_we,
  input  logic [NUM_SLAVES*DW-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  output logic [AW-1:0]            err_addr,
  output logic [7:0]               err_count
);

  localparam int c_CW = clog2_min1(TIMEOUT + 1);
  localparam int c_IW = clog2_min1(NUM_SLAVES);
  localparam int c_BW = DW / 8;

  state_t                r_state, w_next;
  logic [AW-1:0]         r_addr, w_addr_d;
  logic                  r_rd, w_rd_d;
  logic [c_IW-1:0]       r_idx, w_idx_d;
  logic [c_CW-1:0]       r_cnt, w_cnt_d;

  logic [DW-1:0]         w_cpu_rdata_d;
  logic                  w_cpu_ready_d, w_cpu_err_d;
  logic [NUM_SLAVES-1:0] w_slv_sel_d;
  logic [AW-1:0]         w_slv_addr_d;
  logic [DW-1:0]         w_slv_wdata_d;
  logic                  w_slv_rd_d;
  logic [c_BW-1:0]       w_slv_we_d;
  logic [AW-1:0]         w_err_addr_d;
  logic [7:0]            w_err_count_d;

  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_match_sel;
  logic [c_IW-1:0]       w_match_idx;
  logic [AW-1:0]         w_match_mask;
  logic                  w_req, w_slv_ready, w_timeout;
  logic [DW-1:0]         w_slv_rdata;
  logic [7:0]            w_err_count_inc;

  bus_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .IW         (c_IW)
  ) u_match (
    .addr (cpu_addr),
    .hit  (w_hit),
    .sel  (w_match_sel),
    .idx  (w_match_idx)
  );

  assign w_req           = cpu_rd | (|cpu_we);
  assign w_match_mask    = SLV_MASK[w_match_idx*AW +: AW];
  assign w_slv_ready     = slv_ready[r_idx];
  assign w_slv_rdata     = slv_rdata[r_idx*DW +: DW];
  assign w_timeout       = (TIMEOUT != 0) && (r_cnt == c_CW'(TIMEOUT - 1));
  assign w_err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_req) w_next = w_hit ? c_ST_ACCESS : c_ST_ERR;
      c_ST_ACCESS: begin
        if (w_slv_ready)    w_next = c_ST_DONE;
        else if (w_timeout) w_next = c_ST_ERR;
      end
      default:     w_next = c_ST_IDLE;
    endcase
  end

  // Computes the next value of every registered output alongside the transition.
  always_comb begin
    w_addr_d      = r_addr;
    w_rd_d        = r_rd;
    w_idx_d       = r_idx;
    w_cnt_d       = r_cnt;
    w_cpu_rdata_d = cpu_rdata;
    w_cpu_ready_d = 1'b0;
    w_cpu_err_d   = 1'b0;
    w_slv_sel_d   = slv_sel;
    w_slv_addr_d  = slv_addr;
    w_slv_wdata_d = slv_wdata;
    w_slv_rd_d    = slv_rd;
    w_slv_we_d    = slv_we;
    w_err_addr_d  = err_addr;
    w_err_count_d = err_count;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req) begin
          w_addr_d      = cpu_addr;
          w_rd_d        = cpu_rd & ~(|cpu_we);
          w_idx_d       = w_match_idx;
          w_cnt_d       = '0;
          w_slv_addr_d  = cpu_addr & ~w_match_mask;
          w_slv_wdata_d = cpu_wdata;
          if (w_hit) begin
            w_slv_sel_d = w_match_sel;
            w_slv_rd_d  = cpu_rd & ~(|cpu_we);
            w_slv_we_d  = cpu_we;
          end else begin
            w_cpu_ready_d = 1'b1;
            w_cpu_err_d   = 1'b1;
            w_cpu_rdata_d = ERR_DATA;
            w_err_addr_d  = cpu_addr;
            w_err_count_d = w_err_count_inc;
          end
        end
      end
      c_ST_ACCESS: begin
        w_cnt_d = r_cnt + c_CW'(1);
        if (w_slv_ready || w_timeout) begin
          w_slv_sel_d   = '0;
          w_slv_rd_d    = 1'b0;
          w_slv_we_d    = '0;
          w_cpu_ready_d = 1'b1;
          if (w_slv_ready) begin
            w_cpu_rdata_d = r_rd ? w_slv_rdata : '0;
          end else begin
            w_cpu_err_d   = 1'b1;
            w_cpu_rdata_d = ERR_DATA;
            w_err_addr_d  = r_addr;
            w_err_count_d = w_err_count_inc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_rd      <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      slv_sel   <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_rd    <= 1'b0;
      slv_we    <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      r_addr    <= w_addr_d;
      r_rd      <= w_rd_d;
      r_idx     <= w_idx_d;
      r_cnt     <= w_cnt_d;
      cpu_rdata <= w_cpu_rdata_d;
      cpu_ready <= w_cpu_ready_d;
      cpu_err   <= w_cpu_err_d;
      slv_sel   <= w_slv_sel_d;
      slv_addr  <= w_slv_addr_d;
      slv_wdata <= w_slv_wdata_d;
      slv_rd    <= w_slv_rd_d;
      slv_we    <= w_slv_we_d;
      err_addr  <= w_err_addr_d;
      err_count <= w_err_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_fabric_n.sv
// ============================================================================
// Module   : tb_bus_fabric_n
// Brief    : Directed, table-driven bench for bus_fabric_n.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_fabric_n;

  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // Slave 0 has a wide window overlapping slave 2; 0x7xxx_xxxx is unmapped.
  localparam logic [NS*AW-1:0] BASE = {32'h8000_0000, 32'h6000_0000, 32'h5000_0000,
                                       32'h4000_0000, 32'h3000_0000, 32'h2000_0000,
                                       32'h1000_0000, 32'h2000_0000};
  localparam logic [NS*AW-1:0] MASK = {{7{32'hFFFF_0000}}, 32'hFF00_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_rd;
  logic [BW-1:0]     cpu_we;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic [NS-1:0]     slv_sel;
  logic [AW-1:0]     slv_addr;
  logic [DW-1:0]     slv_wdata;
  logic              slv_rd;
  logic [BW-1:0]     slv_we;
  logic [NS*DW-1:0]  slv_rdata;
  logic [NS-1:0]     slv_ready;
  logic [AW-1:0]     err_addr;
  logic [7:0]        err_count;

  int n_checks = 0;
  int n_err    = 0;

  // Per-slave wait states; 0 means ready tied high, 255 means never ready.
  int wait_cfg [NS] = '{0, 0, 0, 3, 1, 255, 0, 0};
  int acc_cnt;

  always #5 clk = ~clk;

  bus_fabric_n #(
    .NUM_SLAVES (NS),
    .AW         (AW),
    .DW         (DW),
    .SLV_BASE   (BASE),
    .SLV_MASK   (MASK),
    .TIMEOUT    (4),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .slv_sel   (slv_sel),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rd    (slv_rd),
    .slv_we    (slv_we),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)             acc_cnt <= 0;
    else if (slv_sel == '0) acc_cnt <= 0;
    else                 acc_cnt <= acc_cnt + 1;
  end

  for (genvar i = 0; i < NS; i++) begin : g_slv
    assign slv_rdata[i*DW +: DW] = (i == 1) ? 32'h1234_5678 : 32'hA000_0000 + i;
    assign slv_ready[i] = (wait_cfg[i] == 0) || (slv_sel[i] && (acc_cnt >= wait_cfg[i]));
  end

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic [BW-1:0] we;
    int            exp_cyc;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [NS-1:0] exp_sel;
    logic [AW-1:0] exp_saddr;
    logic          exp_srd;
    logic [BW-1:0] exp_swe;
    logic [7:0]    exp_ecnt;
    logic [AW-1:0] exp_eaddr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge (cycle 0 ends at the next posedge) and
  // holds it until cpu_ready.
  task automatic run_txn(input vec_t v);
    int  cyc;
    int  sel_cyc;
    bit  seen;
    logic [DW-1:0] rdata_at_ready;
    @(negedge clk);
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_rd    = v.rd;
    cpu_we    = v.we;
    cyc = 0; sel_cyc = 0; seen = 0;
    rdata_at_ready = '0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (slv_sel != '0) sel_cyc++;
      if (cyc == 1) begin
        chk({v.name, " sel"}, 32'(slv_sel), 32'(v.exp_sel));
        chk({v.name, " slv_rd"}, 32'(slv_rd), 32'(v.exp_srd));
        chk({v.name, " slv_we"}, 32'(slv_we), 32'(v.exp_swe));
        if (v.exp_sel != '0) begin
          chk({v.name, " slv_addr"}, slv_addr, v.exp_saddr);
          chk({v.name, " slv_wdata"}, slv_wdata, v.wdata);
        end
      end
      if (cpu_ready) begin
        seen = 1;
        rdata_at_ready = cpu_rdata;
      end
    end
    cpu_rd = 1'b0;
    cpu_we = '0;
    chk({v.name, " ready cycle"}, seen ? cyc : -1, v.exp_cyc);
    chk({v.name, " err"}, 32'(cpu_err), 32'(v.exp_err));
    chk({v.name, " rdata"}, rdata_at_ready, v.exp_rdata);
    chk({v.name, " sel cleared"}, 32'(slv_sel), 32'h0);
    chk({v.name, " sel cycles"}, sel_cyc, (v.exp_sel != '0) ? v.exp_cyc - 1 : 0);
    chk({v.name, " err_count"}, 32'(err_count), 32'(v.exp_ecnt));
    chk({v.name, " err_addr"}, err_addr, v.exp_eaddr);
    @(posedge clk); #1;
    chk({v.name, " ready pulse"}, 32'(cpu_ready), 32'h0);
    chk({v.name, " rdata hold"}, cpu_rdata, v.exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   rc [3];
    int   nrc;
    vec_t v;

    vecs[0] = '{"zero-wait read", 32'h1000_0024, 32'h0, 1'b1, 4'b0000,
                2, 1'b0, 32'h1234_5678, 8'b0000_0010, 32'h24, 1'b1, 4'b0000, 8'd0, 32'h0};
    vecs[1] = '{"byte write 3 waits", 32'h3000_0010, 32'h00AB_0000, 1'b0, 4'b0100,
                5, 1'b0, 32'h0, 8'b0000_1000, 32'h10, 1'b0, 4'b0100, 8'd0, 32'h0};
    vecs[2] = '{"unmapped", 32'h7000_0000, 32'h0, 1'b1, 4'b0000,
                1, 1'b1, 32'hDEAD_BEEF, 8'b0, 32'h0, 1'b0, 4'b0000, 8'd1, 32'h7000_0000};
    vecs[3] = '{"overlap rd+we", 32'h2000_0044, 32'h5555_AAAA, 1'b1, 4'b1111,
                2, 1'b0, 32'h0, 8'b0000_0001, 32'h44, 1'b0, 4'b1111, 8'd1, 32'h7000_0000};
    vecs[4] = '{"one-wait read", 32'h4000_0100, 32'h0, 1'b1, 4'b0000,
                3, 1'b0, 32'hA000_0004, 8'b0001_0000, 32'h100, 1'b1, 4'b0000, 8'd1, 32'h7000_0000};
    vecs[5] = '{"timeout", 32'h5000_0008, 32'h0, 1'b1, 4'b0000,
                5, 1'b1, 32'hDEAD_BEEF, 8'b0010_0000, 32'h8, 1'b1, 4'b0000, 8'd2, 32'h5000_0008};

    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_we = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cpu_ready", 32'(cpu_ready), 32'h0);
    chk("reset cpu_err", 32'(cpu_err), 32'h0);
    chk("reset cpu_rdata", cpu_rdata, 32'h0);
    chk("reset slv_sel", 32'(slv_sel), 32'h0);
    chk("reset slv_addr", slv_addr, 32'h0);
    chk("reset slv_wdata", slv_wdata, 32'h0);
    chk("reset slv_rd/we", {27'h0, slv_rd, slv_we}, 32'h0);
    chk("reset err_addr", err_addr, 32'h0);
    chk("reset err_count", 32'(err_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Held read: completions every 3 cycles.
    @(negedge clk);
    cpu_addr = 32'h1000_0004; cpu_rd = 1'b1; cpu_we = '0;
    nrc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (cpu_ready && nrc < 3) begin
        rc[nrc] = c;
        nrc++;
      end
    end
    cpu_rd = 1'b0;
    chk("b2b count", nrc, 3);
    chk("b2b first", (nrc > 0) ? rc[0] : -1, 2);
    chk("b2b second", (nrc > 1) ? rc[1] : -1, 5);
    chk("b2b third", (nrc > 2) ? rc[2] : -1, 8);
    @(posedge clk); #1;

    // Request withdrawn after one ACCESS cycle still completes.
    @(negedge clk);
    cpu_addr = 32'h4000_0200; cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    nrc = 0;
    for (int c = 2; c <= 10 && nrc == 0; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) nrc = c;
    end
    chk("withdrawn ready cycle", nrc, 3);
    chk("withdrawn rdata", cpu_rdata, 32'hA000_0004);
    chk("withdrawn err", 32'(cpu_err), 32'h0);
    @(posedge clk); #1;

    // Asynchronous reset while a never-ready slave is being accessed.
    @(negedge clk);
    cpu_addr = 32'h5000_0000; cpu_rd = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset sel", 32'(slv_sel), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst sel", 32'(slv_sel), 32'h0);
    chk("async rst ready", 32'(cpu_ready), 32'h0);
    chk("async rst slv_rd", 32'(slv_rd), 32'h0);
    chk("async rst err_count", 32'(err_count), 32'h0);
    cpu_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    v = vecs[0];
    v.name = "post-reset read";
    run_txn(v);

    // 300 unmapped reads back to back saturate the counter.
    @(negedge clk);
    cpu_addr = 32'h7000_0000; cpu_rd = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_count saturate", 32'(err_count), 32'hFF);
    chk("err_addr after sat", err_addr, 32'h7000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
